// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder that emulates a W25Q-series NOR flash over a small internal
// byte memory. All SPI lines are oversampled and edge-detected in the sclk domain.
module spi_flash_responder #(
    parameter int          MEM_DEPTH   = 256,
    parameter int          BUSY_CYCLES = 1000,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
    input  logic sclk,
    input  logic rst,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic wel
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam logic [AW-1:0] PAGE_MASK = AW'(8'hFF);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA_IN, DATA_OUT, IGNORE, ERASE_SWEEP
    } state_t;

    typedef enum logic [2:0] {
        PEND_NONE, PEND_WREN, PEND_WRDI, PEND_PROG, PEND_ERASE
    } pend_t;

    state_t state, state_next;
    pend_t  pend;

    logic [1:0]    cs_sync, sck_sync, mosi_sync;
    logic          cs_prev, sck_prev;
    logic          cs_s, sck_s, mosi_s;
    logic          cs_fall, cs_rise, sck_rise, sck_fall;
    logic          in_frame, bit_rx, byte_done;
    logic [2:0]    bit_cnt;
    logic [6:0]    shift_in;
    logic [7:0]    byte_in;
    logic [1:0]    addr_cnt;
    logic [AW-1:0] addr_shift, new_addr;
    logic [7:0]    opcode;
    logic [AW-1:0] rd_ptr, prog_addr, prog_addr_inc, sweep_addr;
    logic [7:0]    mem_rdata, tx_byte, jedec_byte;
    logic [1:0]    jedec_idx;
    logic          load_now, load_d1, load_d2, prog_write, sweep_start;
    logic [2:0]    tx_idx;
    logic          miso_q, wel_q, sweep_active;
    logic [BW-1:0] busy_cnt;
    logic [7:0]    mem [MEM_DEPTH];

    always_ff @(posedge sclk) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sck_sync  <= {sck_sync[0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_prev   <= cs_sync[1];
            sck_prev  <= sck_sync[1];
        end
    end

    assign cs_s      = cs_sync[1];
    assign sck_s     = sck_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    // A rising sck in the same cycle as a cs rise is dropped because cs_s is already high.
    assign in_frame  = ~cs_s && !cs_fall && (state inside {CMD, ADDR, DATA_IN, DATA_OUT, IGNORE});
    assign bit_rx    = in_frame & sck_rise;
    assign byte_done = bit_rx && (bit_cnt == 3'd7);
    assign byte_in   = {shift_in, mosi_s};
    assign new_addr  = AW'({addr_shift, byte_in});
    assign busy      = sweep_active | (busy_cnt != '0);
    assign wel       = wel_q;
    assign miso      = miso_q & ~cs;

    always_ff @(posedge sclk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_fall) begin
            state_next = CMD;
        end else if (cs_rise) begin
            state_next = (sweep_active || pend == PEND_ERASE) ? ERASE_SWEEP : IDLE;
        end else if (byte_done) begin
            case (state)
                CMD: begin
                    case (byte_in)
                        8'h05:        state_next = DATA_OUT;
                        8'h9F:        state_next = busy ? IGNORE : DATA_OUT;
                        8'h03:        state_next = busy ? IGNORE : ADDR;
                        8'h02, 8'h20: state_next = (busy || !wel_q) ? IGNORE : ADDR;
                        default:      state_next = IGNORE;
                    endcase
                end
                ADDR: begin
                    if (addr_cnt == 2'd2) begin
                        if (opcode == 8'h03)      state_next = DATA_OUT;
                        else if (opcode == 8'h02) state_next = DATA_IN;
                        else                      state_next = IGNORE;
                    end
                end
                default: state_next = state;
            endcase
        end else if (state == IDLE && sweep_active) begin
            state_next = ERASE_SWEEP;
        end else if (state == ERASE_SWEEP && !sweep_active) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        load_now      = byte_done && (state_next == DATA_OUT);
        prog_write    = byte_done && (state == DATA_IN);
        sweep_start   = cs_rise && (pend == PEND_ERASE);
        tx_idx        = ~bit_cnt;
        prog_addr_inc = (prog_addr & ~PAGE_MASK) | ((prog_addr + AW'(1)) & PAGE_MASK);
        case (jedec_idx)
            2'd0:    jedec_byte = JEDEC_ID[23:16];
            2'd1:    jedec_byte = JEDEC_ID[15:8];
            2'd2:    jedec_byte = JEDEC_ID[7:0];
            default: jedec_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            bit_cnt      <= '0;
            shift_in     <= '0;
            addr_cnt     <= '0;
            addr_shift   <= '0;
            opcode       <= '0;
            pend         <= PEND_NONE;
            rd_ptr       <= '0;
            prog_addr    <= '0;
            jedec_idx    <= '0;
            load_d1      <= 1'b0;
            load_d2      <= 1'b0;
            tx_byte      <= '0;
            miso_q       <= 1'b0;
            wel_q        <= 1'b0;
            busy_cnt     <= '0;
            sweep_active <= 1'b1;
            sweep_addr   <= '0;
        end else begin
            // Response bytes load two cycles after the byte boundary so the memory read has settled.
            load_d1 <= load_now;
            load_d2 <= load_d1;
            if (load_d2) begin
                case (opcode)
                    8'h05: tx_byte <= {6'b0, wel_q, busy};
                    8'h9F: begin
                        tx_byte <= jedec_byte;
                        if (jedec_idx != 2'd3) jedec_idx <= jedec_idx + 2'd1;
                    end
                    default: tx_byte <= mem_rdata;
                endcase
            end

            if (bit_rx) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= byte_in[6:0];
            end

            if (byte_done) begin
                if (state == CMD) begin
                    opcode <= byte_in;
                    if (!busy && byte_in == 8'h06)      pend <= PEND_WREN;
                    else if (!busy && byte_in == 8'h04) pend <= PEND_WRDI;
                end
                if (state == ADDR) begin
                    addr_shift <= new_addr;
                    addr_cnt   <= addr_cnt + 2'd1;
                    if (addr_cnt == 2'd2) begin
                        rd_ptr    <= new_addr;
                        prog_addr <= new_addr;
                        if (opcode == 8'h20) pend <= PEND_ERASE;
                    end
                end
                if (state == DATA_OUT && opcode == 8'h03) rd_ptr <= rd_ptr + AW'(1);
            end

            if (prog_write) begin
                prog_addr <= prog_addr_inc;
                pend      <= PEND_PROG;
            end

            if (cs_fall) begin
                bit_cnt   <= '0;
                addr_cnt  <= '0;
                pend      <= PEND_NONE;
                jedec_idx <= '0;
            end

            if (cs_s || state != DATA_OUT) miso_q <= 1'b0;
            else if (sck_fall)             miso_q <= tx_byte[tx_idx];

            if (busy_cnt != '0) busy_cnt <= busy_cnt - BW'(1);
            if (cs_rise) begin
                case (pend)
                    PEND_WREN: wel_q <= 1'b1;
                    PEND_WRDI: wel_q <= 1'b0;
                    PEND_PROG: begin
                        wel_q    <= 1'b0;
                        busy_cnt <= BW'(BUSY_CYCLES);
                    end
                    default: ;
                endcase
            end

            if (sweep_start) begin
                sweep_active <= 1'b1;
                sweep_addr   <= '0;
            end else if (sweep_active) begin
                sweep_addr <= sweep_addr + AW'(1);
                if (sweep_addr == AW'(MEM_DEPTH - 1)) begin
                    sweep_active <= 1'b0;
                    wel_q        <= 1'b0;
                end
            end
        end
    end

    // Program can only clear bits; the erase sweep owns the write port while it runs.
    always_ff @(posedge sclk) begin
        if (!rst) begin
            if (sweep_active)    mem[sweep_addr] <= 8'hFF;
            else if (prog_write) mem[prog_addr]  <= mem[prog_addr] & byte_in;
        end
        mem_rdata <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder acting as an SPI mode-0 master with
// hand-computed expectations for each flash command.
module tb_spi_flash_responder;
    localparam int MEM_DEPTH   = 256;
    localparam int BUSY_CYCLES = 600;
    localparam int HALF        = 8;

    logic sclk = 1'b0;
    logic rst, cs, sck, mosi;
    logic miso, busy, wel;

    int checkCount = 0;
    int passCount  = 0;
    int n;
    logic [7:0] rx;

    always #5 sclk = ~sclk;

    spi_flash_responder #(
        .MEM_DEPTH  (MEM_DEPTH),
        .BUSY_CYCLES(BUSY_CYCLES),
        .JEDEC_ID   (24'hEF4018)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .cs  (cs),
        .sck (sck),
        .mosi(mosi),
        .miso(miso),
        .busy(busy),
        .wel (wel)
    );

    task automatic waitCycles(input int cycles);
        repeat (cycles) @(negedge sclk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic beginFrame;
        cs = 1'b0;
        waitCycles(HALF);
    endtask

    task automatic endFrame;
        waitCycles(HALF);
        cs = 1'b1;
        waitCycles(HALF);
    endtask

    task automatic applyBits(input logic [7:0] tx, input int bits, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i > 7 - bits; i--) begin
            mosi = tx[i];
            waitCycles(HALF);
            rxb[i] = miso;
            sck = 1'b1;
            waitCycles(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rxb);
        applyBits(tx, 8, rxb);
    endtask

    task automatic sendAddr(input logic [23:0] a);
        logic [7:0] dummy;
        applyStimulus(a[23:16], dummy);
        applyStimulus(a[15:8], dummy);
        applyStimulus(a[7:0], dummy);
    endtask

    task automatic sendCmd(input logic [7:0] op);
        logic [7:0] dummy;
        beginFrame();
        applyStimulus(op, dummy);
        endFrame();
    endtask

    task automatic checkRead(input string tag, input logic [23:0] a, input int count, input logic [31:0] expected);
        logic [7:0] rxb;
        beginFrame();
        applyStimulus(8'h03, rxb);
        sendAddr(a);
        for (int i = 0; i < count; i++) begin
            applyStimulus(8'h00, rxb);
            checkOutput($sformatf("%s_%0d", tag, i), {24'h0, rxb}, {24'h0, expected[31-8*i -: 8]});
        end
        endFrame();
    endtask

    task automatic readStatus(input string tag, input logic [7:0] expected);
        logic [7:0] rxb;
        beginFrame();
        applyStimulus(8'h05, rxb);
        applyStimulus(8'h00, rxb);
        checkOutput(tag, {24'h0, rxb}, {24'h0, expected});
        endFrame();
    endtask

    // Leaves the frame open so the caller decides how cs is raised.
    task automatic programPage(input logic [7:0] op, input logic [23:0] a, input int count, input logic [23:0] data);
        logic [7:0] rxb;
        beginFrame();
        applyStimulus(op, rxb);
        sendAddr(a);
        for (int i = 0; i < count; i++) applyStimulus(data[23-8*i -: 8], rxb);
    endtask

    task automatic endFrameBusy(input string tag, input int expLen);
        int d;
        int len;
        waitCycles(HALF);
        cs = 1'b1;
        d = 0;
        while (!busy && d < 20) begin
            @(negedge sclk);
            d++;
        end
        checkOutput({tag, "_delay"}, d, 3);
        len = 0;
        while (busy && len < 5000) begin
            len++;
            @(negedge sclk);
        end
        checkOutput({tag, "_len"}, len, expLen);
        waitCycles(HALF);
    endtask

    task automatic waitIdle(input string tag);
        int w;
        w = 0;
        while (busy && w < 5000) begin
            @(negedge sclk);
            w++;
        end
        checkOutput(tag, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        waitCycles(4);
        checkOutput("reset_busy", {31'h0, busy}, 32'h1);
        checkOutput("reset_wel", {31'h0, wel}, 32'h0);
        checkOutput("reset_miso", {31'h0, miso}, 32'h0);

        rst = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge sclk);
        end
        checkOutput("reset_sweep_len", n, MEM_DEPTH);
        waitCycles(2);
        checkRead("read_erased", 24'h000000, 4, 32'hFFFFFFFF);

        beginFrame();
        applyStimulus(8'h9F, rx);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] id;
            id = 32'hEF401800;
            applyStimulus(8'h00, rx);
            checkOutput($sformatf("jedec_%0d", i), {24'h0, rx}, {24'h0, id[31-8*i -: 8]});
        end
        endFrame();

        sendCmd(8'h06);
        checkOutput("wren_wel", {31'h0, wel}, 32'h1);
        readStatus("rdsr_wel", 8'h02);
        programPage(8'h02, 24'h000000, 1, 24'h330000);
        endFrameBusy("pp_busy", BUSY_CYCLES);
        checkOutput("pp_wel_cleared", {31'h0, wel}, 32'h0);
        readStatus("rdsr_idle", 8'h00);
        checkRead("read_pp", 24'h000000, 1, 32'h33000000);

        programPage(8'h02, 24'h000010, 1, 24'h000000);
        endFrame();
        checkOutput("nowren_busy", {31'h0, busy}, 32'h0);
        checkOutput("nowren_wel", {31'h0, wel}, 32'h0);
        checkRead("read_nowren", 24'h000010, 1, 32'hFF000000);

        sendCmd(8'h06);
        programPage(8'h02, 24'h000020, 1, 24'hF00000);
        endFrame();
        readStatus("rdsr_busy", 8'h01);
        waitIdle("idle_after_f0");
        readStatus("rdsr_after_busy", 8'h00);
        sendCmd(8'h06);
        programPage(8'h02, 24'h000020, 1, 24'h3C0000);
        endFrame();
        waitIdle("idle_after_3c");
        checkRead("read_and", 24'h000020, 1, 32'h30000000);

        sendCmd(8'h06);
        programPage(8'h02, 24'h0000FF, 3, 24'h5A1177);
        endFrame();
        waitIdle("idle_after_wrap");
        checkRead("read_wrap", 24'h0000FF, 3, 32'h5A117700);

        sendCmd(8'h06);
        programPage(8'h02, 24'h000040, 0, 24'h000000);
        applyBits(8'h00, 4, rx);
        endFrame();
        checkOutput("partial_busy", {31'h0, busy}, 32'h0);
        checkOutput("partial_wel", {31'h0, wel}, 32'h1);
        checkRead("read_partial", 24'h000040, 1, 32'hFF000000);

        programPage(8'h20, 24'h000000, 0, 24'h000000);
        endFrameBusy("erase_busy", MEM_DEPTH);
        checkOutput("erase_wel", {31'h0, wel}, 32'h0);
        checkRead("read_erase_wrap", 24'h0000FE, 4, 32'hFFFFFFFF);
        checkRead("read_erase_20", 24'h000020, 1, 32'hFF000000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
